// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: FSM states, datapath width and PC defaults.
package pc_gen_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [1:0] {
    StReset,
    StRun,
    StTrap
  } pc_state_e;

endpackage

// File: rtl/pc_gen_target_calc.sv
// Redirect target selection: jump beats branch; flags targets not on a word boundary.
module pc_gen_target_calc
  import pc_gen_pkg::*;
(
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic [XLEN-1:0] branch_offset_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;

  // Offset arrives pre-shifted, so a plain add gives the byte target; carry is dropped.
  assign branch_target = branch_pc_i + branch_offset_i;
  assign jump_target   = jump_target_i & ~{{(XLEN-1){1'b0}}, 1'b1};

  always_comb begin
    redirect_o = jump_i | branch_taken_i;
    target_o   = jump_i ? jump_target : branch_target;
  end

  assign misaligned_o = redirect_o && (target_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, branch/jump redirect, misalignment trap.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic [XLEN-1:0] branch_offset_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_addr_o
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] trap_addr_q;
  logic            flush_q;
  logic            trap_q;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misaligned;

  pc_gen_target_calc u_target_calc (
    .branch_taken_i  (branch_taken_i),
    .branch_pc_i     (branch_pc_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .redirect_o      (redirect),
    .target_o        (target),
    .misaligned_o    (misaligned)
  );

  // Deliberately independent of fetch_ready_i to keep the request path free of loops.
  assign fetch_valid_o = (state_q == StRun) && !stall_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StReset;
      pc_q        <= RESET_PC;
      trap_addr_q <= '0;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      unique case (state_q)
        StReset: state_q <= StRun;
        StRun: begin
          if (redirect) begin
            flush_q <= 1'b1;
            if (misaligned) begin
              pc_q        <= TRAP_VEC;
              trap_addr_q <= target;
              trap_q      <= 1'b1;
              state_q     <= StTrap;
            end else begin
              pc_q <= target;
            end
          end else if (fetch_valid_o && fetch_ready_i) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        // Redirects landing during the trap cycle are dropped on purpose.
        StTrap:  state_q <= StRun;
        default: state_q <= StReset;
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign flush_o     = flush_q;
  assign trap_o      = trap_q;
  assign trap_addr_o = trap_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, back-pressure, redirects, trap, stall, wrap, reset.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        fetch_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        trap;
  logic [31:0] trap_addr;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .stall_i         (stall),
    .fetch_ready_i   (fetch_ready),
    .branch_taken_i  (branch_taken),
    .branch_pc_i     (branch_pc),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .pc_o            (pc),
    .fetch_valid_o   (fetch_valid),
    .flush_o         (flush),
    .trap_o          (trap),
    .trap_addr_o     (trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    branch_taken = 1'b0; branch_pc = '0; branch_offset = '0;
    jump = 1'b0; jump_target = '0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_trap", {31'b0, trap}, 32'h0);
    chk("rst_trap_addr", trap_addr, 32'h0);
    tick();
    chk("rst_held_valid", {31'b0, fetch_valid}, 32'h0);
    rst_n = 1'b1;

    // First edge leaves RESET without advancing.
    tick();
    chk("run_pc0", pc, 32'h0);
    chk("run_valid", {31'b0, fetch_valid}, 32'h1);
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); tick(); chk("seq_pc10", pc, 32'h10);

    // Back-pressure from instruction memory.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", pc, 32'h10);
      chk("hold_valid", {31'b0, fetch_valid}, 32'h1);
    end
    fetch_ready = 1'b1;
    tick(); chk("resume_pc14", pc, 32'h14);

    // Taken branch with negative offset.
    branch_taken = 1'b1; branch_pc = 32'h40; branch_offset = 32'hFFFF_FFF0;
    tick();
    chk("br_pc", pc, 32'h30);
    chk("br_flush", {31'b0, flush}, 32'h1);
    branch_taken = 1'b0;
    tick();
    chk("br_next_pc", pc, 32'h34);
    chk("br_flush_drop", {31'b0, flush}, 32'h0);

    // Jump wins over a simultaneous branch; bit 0 of the target is cleared.
    branch_taken = 1'b1; jump = 1'b1; jump_target = 32'h201;
    tick();
    chk("jmp_pri_pc", pc, 32'h200);
    chk("jmp_pri_flush", {31'b0, flush}, 32'h1);
    branch_taken = 1'b0; jump = 1'b0;
    tick(); chk("jmp_next_pc", pc, 32'h204);

    // Misaligned branch target traps.
    branch_taken = 1'b1; branch_pc = 32'h40; branch_offset = 32'h2;
    tick();
    chk("trap_pc", pc, 32'h100);
    chk("trap_pulse", {31'b0, trap}, 32'h1);
    chk("trap_flush", {31'b0, flush}, 32'h1);
    chk("trap_addr", trap_addr, 32'h42);
    chk("trap_valid", {31'b0, fetch_valid}, 32'h0);
    branch_taken = 1'b0;
    jump = 1'b1; jump_target = 32'h300;
    tick();
    chk("trap_ign_pc", pc, 32'h100);
    chk("trap_pulse_drop", {31'b0, trap}, 32'h0);
    chk("trap_flush_drop", {31'b0, flush}, 32'h0);
    chk("trap_addr_held", trap_addr, 32'h42);
    chk("trap_exit_valid", {31'b0, fetch_valid}, 32'h1);
    jump = 1'b0;
    tick(); chk("post_trap_pc", pc, 32'h104);

    // Jump to 0x20, then a stalled jump to 0x80 on the very next cycle.
    jump = 1'b1; jump_target = 32'h20;
    tick(); chk("pre_stall_pc", pc, 32'h20);
    stall = 1'b1; jump_target = 32'h80;
    #1;
    chk("stall_valid", {31'b0, fetch_valid}, 32'h0);
    tick();
    chk("stall_jmp_pc", pc, 32'h80);
    chk("b2b_flush", {31'b0, flush}, 32'h1);
    chk("stall_valid2", {31'b0, fetch_valid}, 32'h0);
    jump = 1'b0;
    tick();
    chk("stall_hold_pc", pc, 32'h80);
    chk("stall_flush_drop", {31'b0, flush}, 32'h0);
    stall = 1'b0;
    #1;
    chk("unstall_valid", {31'b0, fetch_valid}, 32'h1);
    tick(); chk("unstall_pc", pc, 32'h84);

    // Sequential wrap at the top of the address space.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_no_trap", {31'b0, trap}, 32'h0);

    // Reset asserted mid-cycle while a redirect is in flight.
    jump = 1'b1; jump_target = 32'h500;
    tick();
    chk("pre_rst_pc", pc, 32'h500);
    jump_target = 32'h600;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_flush", {31'b0, flush}, 32'h0);
    chk("async_rst_trap", {31'b0, trap}, 32'h0);
    chk("async_rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("async_rst_trap_addr", trap_addr, 32'h0);
    tick();
    chk("rst_hold_pc", pc, 32'h0);
    jump = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
